// File: rtl/regbank_write_scheduler_if.sv
// Write-port sharing bus: two writeback requesters, bank write port, decode scoreboard queries.
interface regbank_write_scheduler_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              rf_regwrite;
  logic [ADDR_W-1:0] rf_write_end;
  logic [DATA_W-1:0] rf_write_in;
  logic [ADDR_W-1:0] query_addr1;
  logic [ADDR_W-1:0] query_addr2;
  logic              busy1;
  logic              busy2;
  logic              idle;

  // Requesters and decode side.
  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, query_addr1, query_addr2,
    input  a_ready, b_ready, rf_regwrite, rf_write_end, rf_write_in, busy1, busy2, idle
  );

  // Scheduler side.
  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, query_addr1, query_addr2,
    output a_ready, b_ready, rf_regwrite, rf_write_end, rf_write_in, busy1, busy2, idle
  );
endinterface

// File: rtl/regbank_write_scheduler.sv
// Round-robin scheduler sharing the register bank's single write port between
// two 1-deep writeback buffers, with a pending-write scoreboard for decode.
module regbank_write_scheduler #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                     clock,
  input  logic                     reset_n,
  regbank_write_scheduler_if.slave bus
);

  localparam int unsigned NREG = 1 << ADDR_W;

  logic              a_full_q, a_full_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d;
  logic [DATA_W-1:0] a_data_q, a_data_d;
  logic              b_full_q, b_full_d;
  logic [ADDR_W-1:0] b_addr_q, b_addr_d;
  logic [DATA_W-1:0] b_data_q, b_data_d;
  logic              rr_ptr_q, rr_ptr_d;     // 0: A favoured, 1: B favoured
  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] wr_end_q, wr_end_d;
  logic [DATA_W-1:0] data1_q, data1_d;       // issue-stage data
  logic [DATA_W-1:0] data2_q, data2_d;       // held for the bank's negedge sample
  logic              s1_vld_q, s1_vld_d;     // entry in commit cycle
  logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
  logic              s2_vld_q, s2_vld_d;     // entry in bank-write cycle
  logic [ADDR_W-1:0] s2_addr_q, s2_addr_d;
  logic [NREG-1:0]   sb_q, sb_d;

  logic              grant_a, grant_b, any_grant;
  logic              acc_a, acc_b, keep_s2;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_data;

  // Arbitration over full buffers and acceptance into empty ones.
  always_comb begin
    grant_a   = a_full_q & (~b_full_q | ~rr_ptr_q);
    grant_b   = b_full_q & (~a_full_q | rr_ptr_q);
    any_grant = grant_a | grant_b;
    g_addr    = grant_a ? a_addr_q : b_addr_q;
    g_data    = grant_a ? a_data_q : b_data_q;
    acc_a     = bus.a_valid & ~a_full_q;
    acc_b     = bus.b_valid & ~b_full_q;
  end

  // Next-state: buffers, pointer, issue/commit pipeline and scoreboard.
  always_comb begin
    a_full_d   = a_full_q;
    a_addr_d   = a_addr_q;
    a_data_d   = a_data_q;
    b_full_d   = b_full_q;
    b_addr_d   = b_addr_q;
    b_data_d   = b_data_q;
    rr_ptr_d   = rr_ptr_q;
    sb_d       = sb_q;
    keep_s2    = 1'b0;

    if (grant_a) a_full_d = 1'b0;
    if (grant_b) b_full_d = 1'b0;
    if (acc_a) begin
      a_full_d = 1'b1;
      a_addr_d = bus.a_addr;
      a_data_d = bus.a_data;
    end
    if (acc_b) begin
      b_full_d = 1'b1;
      b_addr_d = bus.b_addr;
      b_data_d = bus.b_data;
    end

    // Pointer moves only when both sides competed.
    if (a_full_q & b_full_q) rr_ptr_d = ~rr_ptr_q;

    regwrite_d = any_grant & (g_addr != '0);
    wr_end_d   = any_grant ? g_addr : wr_end_q;
    data1_d    = any_grant ? g_data : data1_q;
    data2_d    = data1_q;
    s1_vld_d   = any_grant;
    s1_addr_d  = any_grant ? g_addr : s1_addr_q;
    s2_vld_d   = s1_vld_q;
    s2_addr_d  = s1_addr_q;

    // A later write to the same register keeps the bit set until it lands too.
    keep_s2 = (a_full_q & (a_addr_q == s2_addr_q)) |
              (b_full_q & (b_addr_q == s2_addr_q)) |
              (s1_vld_q & (s1_addr_q == s2_addr_q));
    if (s2_vld_q & ~keep_s2) sb_d[s2_addr_q] = 1'b0;
    if (acc_a & (bus.a_addr != '0)) sb_d[bus.a_addr] = 1'b1;
    if (acc_b & (bus.b_addr != '0)) sb_d[bus.b_addr] = 1'b1;
  end

  // State registers; reset drops everything in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_full_q   <= 1'b0;
      a_addr_q   <= '0;
      a_data_q   <= '0;
      b_full_q   <= 1'b0;
      b_addr_q   <= '0;
      b_data_q   <= '0;
      rr_ptr_q   <= 1'b0;
      regwrite_q <= 1'b0;
      wr_end_q   <= '0;
      data1_q    <= '0;
      data2_q    <= '0;
      s1_vld_q   <= 1'b0;
      s1_addr_q  <= '0;
      s2_vld_q   <= 1'b0;
      s2_addr_q  <= '0;
      sb_q       <= '0;
    end else begin
      a_full_q   <= a_full_d;
      a_addr_q   <= a_addr_d;
      a_data_q   <= a_data_d;
      b_full_q   <= b_full_d;
      b_addr_q   <= b_addr_d;
      b_data_q   <= b_data_d;
      rr_ptr_q   <= rr_ptr_d;
      regwrite_q <= regwrite_d;
      wr_end_q   <= wr_end_d;
      data1_q    <= data1_d;
      data2_q    <= data2_d;
      s1_vld_q   <= s1_vld_d;
      s1_addr_q  <= s1_addr_d;
      s2_vld_q   <= s2_vld_d;
      s2_addr_q  <= s2_addr_d;
      sb_q       <= sb_d;
    end
  end

  // Output drive.
  assign bus.a_ready      = ~a_full_q;
  assign bus.b_ready      = ~b_full_q;
  assign bus.rf_regwrite  = regwrite_q;
  assign bus.rf_write_end = wr_end_q;
  assign bus.rf_write_in  = data2_q;
  assign bus.busy1        = sb_q[bus.query_addr1];
  assign bus.busy2        = sb_q[bus.query_addr2];
  assign bus.idle         = ~(a_full_q | b_full_q | s1_vld_q | s2_vld_q);

endmodule

// File: tb/tb_regbank_write_scheduler.sv
// Bench for regbank_write_scheduler: issue-log reference model, bank model, directed + random stimulus.
module tb_regbank_write_scheduler;

  logic clk;
  logic rst_n;

  regbank_write_scheduler_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regbank_write_scheduler #(.DATA_W(32), .ADDR_W(5)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: buffers, favoured side, and a log of issued writes.
  typedef struct {
    int          cyc;
    logic [4:0]  addr;
    logic [31:0] data;
  } iss_t;

  iss_t        log_q[$];
  bit [1:0]    m_full = 2'b00;
  logic [4:0]  m_addr [2];
  logic [31:0] m_data [2];
  int          m_fav = 0;
  int          m_win;
  bit [1:0]    m_acc;
  int          cur = 0;
  logic [31:0] ref_mem [32];
  logic [31:0] bank [32];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_full = 2'b00;
      m_fav  = 0;
      log_q.delete();
    end else begin
      m_win = -1;
      if (m_full == 2'b11) begin
        m_win = m_fav;
        m_fav = 1 - m_fav;
      end else if (m_full[0]) m_win = 0;
      else if (m_full[1]) m_win = 1;
      m_acc[0] = bus.a_valid && !m_full[0];
      m_acc[1] = bus.b_valid && !m_full[1];
      if (m_win >= 0) begin
        log_q.push_back('{cyc: cur, addr: m_addr[m_win], data: m_data[m_win]});
        m_full[m_win] = 1'b0;
      end
      if (m_acc[0]) begin m_full[0] = 1'b1; m_addr[0] = bus.a_addr; m_data[0] = bus.a_data; end
      if (m_acc[1]) begin m_full[1] = 1'b1; m_addr[1] = bus.b_addr; m_data[1] = bus.b_data; end
      cur++;
      // Writes issued two cycles ago reach the bank during this cycle.
      foreach (log_q[i])
        if (log_q[i].cyc == cur - 2 && log_q[i].addr != 0) ref_mem[log_q[i].addr] = log_q[i].data;
      while (log_q.size() > 4) void'(log_q.pop_front());
    end
  end

  function automatic bit exp_busy(input logic [4:0] q);
    if (q == 0) return 1'b0;
    if (m_full[0] && m_addr[0] == q) return 1'b1;
    if (m_full[1] && m_addr[1] == q) return 1'b1;
    foreach (log_q[i]) if (log_q[i].cyc >= cur - 2 && log_q[i].addr == q) return 1'b1;
    return 1'b0;
  endfunction

  // Per-cycle compare of every DUT output against the model.
  logic        e_we, e_infl;
  logic [4:0]  e_end;
  logic [31:0] e_in;
  always @(negedge clk) begin
    e_we = 1'b0; e_end = '0; e_in = '0; e_infl = 1'b0;
    foreach (log_q[i]) begin
      if (log_q[i].cyc == cur - 1 && log_q[i].addr != 0) e_we = 1'b1;
      if (log_q[i].cyc <= cur - 1) e_end = log_q[i].addr;
      if (log_q[i].cyc <= cur - 2) e_in = log_q[i].data;
      if (log_q[i].cyc >= cur - 2) e_infl = 1'b1;
    end
    chk("m_a_ready",  bus.a_ready,      !m_full[0]);
    chk("m_b_ready",  bus.b_ready,      !m_full[1]);
    chk("m_regwrite", bus.rf_regwrite,  e_we);
    chk("m_wr_end",   bus.rf_write_end, e_end);
    chk("m_wr_in",    bus.rf_write_in,  e_in);
    chk("m_busy1",    bus.busy1,        exp_busy(bus.query_addr1));
    chk("m_busy2",    bus.busy2,        exp_busy(bus.query_addr2));
    chk("m_idle",     bus.idle,         (m_full == 2'b00) && !e_infl);
  end

  // Bank model: flag/address captured at posedge, data written at the following negedge.
  logic       bk_pend = 1'b0;
  logic [4:0] bk_a = '0;
  always @(negedge clk) begin
    if (bk_pend) bank[bk_a] = bus.rf_write_in;
    bk_pend = rst_n && bus.rf_regwrite;
    bk_a    = bus.rf_write_end;
  end

  // Stimulus-side observations.
  logic a_rdy_s = 1'b1, b_rdy_s = 1'b1;
  int   pulse_q[$];
  always @(negedge clk) begin
    a_rdy_s = bus.a_ready;
    b_rdy_s = bus.b_ready;
    if (rst_n && bus.rf_regwrite) pulse_q.push_back(int'(bus.rf_write_end));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.idle) begin ok = 1'b1; break; end
    end
    chk(nm, ok, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int ia, ib;

  initial begin
    for (int i = 0; i < 32; i++) begin bank[i] = '0; ref_mem[i] = '0; end
    rst_n = 1'b0;
    bus.a_valid = 0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_valid = 0; bus.b_addr = '0; bus.b_data = '0;
    bus.query_addr1 = '0; bus.query_addr2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_ready", bus.a_ready, 1);
    chk("rst_b_ready", bus.b_ready, 1);
    chk("rst_regwrite", bus.rf_regwrite, 0);
    chk("rst_wr_end", bus.rf_write_end, 0);
    chk("rst_wr_in", bus.rf_write_in, 0);
    chk("rst_idle", bus.idle, 1);
    step(); rst_n = 1'b1;

    // Single write A: reg7 = DEADBEEF.
    step(); bus.a_valid = 1; bus.a_addr = 5'd7; bus.a_data = 32'hDEADBEEF; bus.query_addr1 = 5'd7;
    @(negedge clk); chk("t1_ready0", bus.a_ready, 1); chk("t1_busy0", bus.busy1, 0);
    step(); bus.a_valid = 0;
    @(negedge clk); chk("t1_ready1", bus.a_ready, 0); chk("t1_busy1", bus.busy1, 1);
    chk("t1_we1", bus.rf_regwrite, 0);
    step(); @(negedge clk);
    chk("t1_we2", bus.rf_regwrite, 1); chk("t1_end2", bus.rf_write_end, 7); chk("t1_busy2", bus.busy1, 1);
    step(); @(negedge clk);
    chk("t1_we3", bus.rf_regwrite, 0); chk("t1_in3", bus.rf_write_in, 32'hDEADBEEF); chk("t1_busy3", bus.busy1, 1);
    step(); @(negedge clk);
    chk("t1_in4", bus.rf_write_in, 32'hDEADBEEF); chk("t1_busy4", bus.busy1, 0);
    chk("t1_idle4", bus.idle, 1); chk("t1_bank7", bank[7], 32'hDEADBEEF);

    // B writes address 0: drained without a bank write.
    step(); bus.b_valid = 1; bus.b_addr = 5'd0; bus.b_data = 32'h1234; bus.query_addr2 = 5'd0;
    @(negedge clk); chk("t3_ready0", bus.b_ready, 1);
    step(); bus.b_valid = 0;
    @(negedge clk); chk("t3_ready1", bus.b_ready, 0); chk("t3_busy1", bus.busy2, 0);
    step(); @(negedge clk);
    chk("t3_ready2", bus.b_ready, 1); chk("t3_we2", bus.rf_regwrite, 0); chk("t3_end2", bus.rf_write_end, 0);
    step(); @(negedge clk); chk("t3_we3", bus.rf_regwrite, 0);
    step(); @(negedge clk); chk("t3_idle", bus.idle, 1); chk("t3_bank0", bank[0], 0);

    // A and B to reg5 in the same cycle; B's value must be final.
    step(); bus.a_valid = 1; bus.a_addr = 5'd5; bus.a_data = 32'h11;
    bus.b_valid = 1; bus.b_addr = 5'd5; bus.b_data = 32'h22; bus.query_addr1 = 5'd5;
    step(); bus.a_valid = 0; bus.b_valid = 0;
    @(negedge clk); chk("t4_busy1", bus.busy1, 1); chk("t4_ar1", bus.a_ready, 0); chk("t4_br1", bus.b_ready, 0);
    step(); @(negedge clk);
    chk("t4_we2", bus.rf_regwrite, 1); chk("t4_ar2", bus.a_ready, 1); chk("t4_br2", bus.b_ready, 0);
    step(); @(negedge clk);
    chk("t4_we3", bus.rf_regwrite, 1); chk("t4_in3", bus.rf_write_in, 32'h11); chk("t4_busy3", bus.busy1, 1);
    step(); @(negedge clk);
    chk("t4_we4", bus.rf_regwrite, 0); chk("t4_in4", bus.rf_write_in, 32'h22); chk("t4_busy4", bus.busy1, 1);
    step(); @(negedge clk);
    chk("t4_busy5", bus.busy1, 0); chk("t4_idle5", bus.idle, 1); chk("t4_bank5", bank[5], 32'h22);

    // Back-to-back from A: reg3 then reg4.
    step(); bus.a_valid = 1; bus.a_addr = 5'd3; bus.a_data = 32'h33;
    @(negedge clk); chk("t5_ready0", bus.a_ready, 1);
    step(); bus.a_addr = 5'd4; bus.a_data = 32'h44;
    @(negedge clk); chk("t5_ready1", bus.a_ready, 0);
    step(); @(negedge clk);
    chk("t5_ready2", bus.a_ready, 1); chk("t5_we2", bus.rf_regwrite, 1); chk("t5_end2", bus.rf_write_end, 3);
    step(); bus.a_valid = 0;
    @(negedge clk); chk("t5_we3", bus.rf_regwrite, 0);
    step(); @(negedge clk);
    chk("t5_we4", bus.rf_regwrite, 1); chk("t5_end4", bus.rf_write_end, 4);
    chk("t5_in4", bus.rf_write_in, 32'h33); chk("t5_bank3", bank[3], 32'h33);
    step(); @(negedge clk); chk("t5_we5", bus.rf_regwrite, 0);
    step(); @(negedge clk); chk("t5_in6", bus.rf_write_in, 32'h44); chk("t5_bank4", bank[4], 32'h44);

    // Reset asserted in the commit cycle of a reg9 write.
    step(); bus.a_valid = 1; bus.a_addr = 5'd9; bus.a_data = 32'h5A5A0009; bus.query_addr1 = 5'd9;
    step(); bus.a_valid = 0;
    step(); #1;
    chk("t6_we_pre", bus.rf_regwrite, 1);
    rst_n = 1'b0; #1;
    chk("t6_we", bus.rf_regwrite, 0); chk("t6_idle", bus.idle, 1);
    chk("t6_ar", bus.a_ready, 1); chk("t6_br", bus.b_ready, 1); chk("t6_busy", bus.busy1, 0);
    step(); step(); rst_n = 1'b1;
    @(negedge clk); chk("t6_bank9", bank[9], 0);

    // Contention from reset: A sends 1,3,5,7 and B 2,4,6,8, valid whenever data remains.
    pulse_q.delete();
    ia = 0; ib = 0;
    for (int c = 0; c < 40 && !(ia == 4 && ib == 4); c++) begin
      @(posedge clk);
      if (bus.a_valid && a_rdy_s) ia++;
      if (bus.b_valid && b_rdy_s) ib++;
      #1;
      bus.a_valid = (ia < 4); bus.a_addr = 5'(1 + 2 * ia); bus.a_data = 32'h1000_0000 | 32'(1 + 2 * ia);
      bus.b_valid = (ib < 4); bus.b_addr = 5'(2 + 2 * ib); bus.b_data = 32'h2000_0000 | 32'(2 + 2 * ib);
    end
    chk("t2_accepts", (ia == 4 && ib == 4), 1);
    bus.a_valid = 0; bus.b_valid = 0;
    wait_idle("t2_idle");
    chk("t2_pulse_count", pulse_q.size(), 8);
    for (int i = 0; i < 8 && i < pulse_q.size(); i++)
      chk($sformatf("t2_grant%0d", i), pulse_q[i], i + 1);
    repeat (2) step();
    chk("t2_bank1", bank[1], 32'h1000_0001);
    chk("t2_bank8", bank[8], 32'h2000_0008);

    // Random traffic, biased to low addresses for collisions.
    for (int c = 0; c < 400; c++) begin
      step();
      bus.a_valid = ($urandom_range(0, 99) < 60);
      bus.a_addr  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      bus.a_data  = $urandom;
      bus.b_valid = ($urandom_range(0, 99) < 60);
      bus.b_addr  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      bus.b_data  = $urandom;
      bus.query_addr1 = 5'($urandom_range(0, 7));
      bus.query_addr2 = 5'($urandom_range(0, 7));
    end
    step(); bus.a_valid = 0; bus.b_valid = 0;
    wait_idle("rnd_idle");
    repeat (3) step();
    for (int i = 0; i < 32; i++) chk($sformatf("bank%0d", i), bank[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regbank_write_scheduler.md
Name: regbank_write_scheduler

Overview:
- Shares the register bank's single write port between two writeback requesters: req A (ALU/execute writeback) and req B (load/OS-context writeback).
- Each requester has a 1-deep holding buffer. A round-robin arbiter grants one write per cycle.
- Drives the bank's RegWrite, write address and write data, honouring the bank's split timing: address and flag are sampled at posedge, data is sampled at the following negedge.
- Keeps a pending-write scoreboard so decode can stall on registers with writes still in flight.

Parameters:
- DATA_W, 32, data width of register values
- ADDR_W, 5, register address width (2**ADDR_W registers)

Ports:
- clock  in  1  system clock; all state updates on posedge
- reset_n  in  1  asynchronous active-low reset
- a_valid  in  1  requester A write request
- a_ready  out  1  A buffer empty, request will be accepted
- a_addr  in  ADDR_W  A destination register
- a_data  in  DATA_W  A write value
- b_valid  in  1  requester B write request
- b_ready  out  1  B buffer empty
- b_addr  in  ADDR_W  B destination register
- b_data  in  DATA_W  B write value
- rf_regwrite  out  1  to bank RegWrite
- rf_write_end  out  ADDR_W  to bank write_end
- rf_write_in  out  DATA_W  to bank write_in
- query_addr1  in  ADDR_W  scoreboard query 1 (decode source 1)
- query_addr2  in  ADDR_W  scoreboard query 2 (decode source 2)
- busy1  out  1  query_addr1 has a pending write (combinational)
- busy2  out  1  query_addr2 has a pending write (combinational)
- idle  out  1  both buffers empty and no write in flight

Behaviour:
- Reset (async, reset_n=0), all outputs deterministic immediately:
  - both buffers empty; a_ready=b_ready=1
  - rf_regwrite=0, rf_write_end=0, rf_write_in=0
  - scoreboard all 0; busy1=busy2=0; idle=1
  - round-robin pointer favours A
- Accept:
  - x_valid && x_ready at posedge loads x_addr/x_data into buffer x; x_ready drops the next cycle.
  - Sets scoreboard bit x_addr, except for address 0, which is never marked.
- Arbitration, combinational each cycle over the full buffers:
  - One full buffer: it wins.
  - Both full: the pointer side wins, then the pointer flips to the other side.
  - The pointer changes only when both were full.
- Issue stage, cycle N, grant of entry (addr, data):
  - At posedge ending N: rf_regwrite <= (addr!=0), rf_write_end <= addr, data_q <= data.
  - The granted buffer empties; x_ready=1 in N+1.
  - The buffer may be refilled at that same posedge only if it was empty at the start of N. There is no same-edge pass-through.
- Commit, cycle N+1:
  - rf_write_in = data_q, stable for the whole cycle so the bank's negedge sample is valid.
  - The bank registers rf_regwrite/rf_write_end at the posedge starting N+2 and writes at negedge of N+2. rf_write_in therefore holds data_q through N+2.
  - Consequently data_q is a 2-stage hold (data_q1 -> data_q2), and rf_write_in = data_q2.
- Scoreboard clear:
  - The bit is cleared at the posedge after the bank's negedge write, i.e. end of N+2.
  - If a new accept targets the same address on that same edge, set wins.
- Address 0: the request is accepted and drained normally, but rf_regwrite stays 0; register 0 stays constant zero.
- Same-address ordering:
  - A and B targeting the same register simultaneously: both are issued in grant order; the later grant is the final value.
  - The scoreboard bit stays set until the last of them clears.
- rf_regwrite deasserts the cycle after issue when no grant is made: single-cycle pulses, back-to-back pulses on consecutive grants.
- Throughput: 1 write/cycle sustained; each requester individually gets 1 write every 2 cycles under contention.
- idle = both buffers empty && no entry in issue/commit pipeline.
- reset_n asserted mid-operation: in-flight writes are dropped, rf_regwrite forced 0 immediately, scoreboard cleared.

Test Plan:
1. Reset then single write: A writes addr 7 = 0xDEADBEEF.
   - Required: rf_regwrite=1, rf_write_end=7 one cycle after accept.
   - rf_write_in=0xDEADBEEF held two cycles; bank reg7 reads 0xDEADBEEF; busy on addr 7 for 3 cycles then 0.
2. Contention: A and B valid every cycle, addrs 1..8.
   - Required: grants alternate A,B,A,B starting with A; no lost or duplicated writes; final bank contents match.
3. Address 0: B writes addr 0 = 0x1234.
   - Required: b_ready returns, rf_regwrite stays 0, bank reg0 reads 0, busy never set.
4. Same address: A and B both write addr 5 (A=0x11, B=0x22) in the same cycle.
   - Required: reg5 ends 0x22; busy1 (query 5) set until the second write commits.
5. Back-to-back from one requester: A writes addr 3 then addr 4 on consecutive ready cycles.
   - Required: a_ready toggles 1,0,1; two rf_regwrite pulses 2 cycles apart; both values land.
6. Reset mid-flight: reset_n low in commit cycle.
   - Required: rf_regwrite=0 immediately, scoreboard 0, idle=1, a_ready=b_ready=1 while reset_n is low.
